// File: rtl/bus_xfer_sequencer.sv
// Register bus-control initiator: turns one move request into ordered per-register
// active-low assert/load strobes. Define XFER_SEQ_GAP_EN to add a turnaround cycle inside OP_MAIN16.
module bus_xfer_sequencer #(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned ADDR_HOLD = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_dst,
  output logic                done,
  output logic                err,
  output logic [NUM_REGS-1:0] assert_addr_n,
  output logic [NUM_REGS-1:0] assert_xfer_n,
  output logic [NUM_REGS-1:0] load_xfer_n,
  output logic [NUM_REGS-1:0] assertlow_main_n,
  output logic [NUM_REGS-1:0] asserthigh_main_n,
  output logic [NUM_REGS-1:0] loadlow_main_n,
  output logic [NUM_REGS-1:0] loadhigh_main_n
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_XFER16 = 2'd0;
  localparam logic [1:0] OP_MAIN16 = 2'd1;
  localparam logic [1:0] OP_ADDR   = 2'd2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_XFER    = 3'd1;
  localparam logic [2:0] S_MAIN_LO = 3'd2;
  localparam logic [2:0] S_MAIN_HI = 3'd3;
  localparam logic [2:0] S_ADDR    = 3'd4;
`ifdef XFER_SEQ_GAP_EN
  localparam logic [2:0] S_GAP     = 3'd5;
`endif

  // Index limit widened by one bit so NUM_REGS == 2**IDX_W is representable.
  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

  logic [2:0]          state_q, state_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] assert_addr_q, assert_addr_d;
  logic [NUM_REGS-1:0] assert_xfer_q, assert_xfer_d;
  logic [NUM_REGS-1:0] load_xfer_q, load_xfer_d;
  logic [NUM_REGS-1:0] assertlow_q, assertlow_d;
  logic [NUM_REGS-1:0] asserthigh_q, asserthigh_d;
  logic [NUM_REGS-1:0] loadlow_q, loadlow_d;
  logic [NUM_REGS-1:0] loadhigh_q, loadhigh_d;
  logic                req_bad;

  assign req_bad = (req_op == 2'd3)
                || ({1'b0, req_src} >= NUM_REGS_W)
                || ((req_op != OP_ADDR) && ({1'b0, req_dst} >= NUM_REGS_W));

  // Next state, then strobes decoded from the next state so every output is a flop.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            src_d = req_src;
            dst_d = req_dst;
            case (req_op)
              OP_XFER16: state_d = S_XFER;
              OP_MAIN16: state_d = S_MAIN_LO;
              default: begin
                state_d = S_ADDR;
                cnt_d   = CNT_W'(ADDR_HOLD - 1);
              end
            endcase
          end
        end
      end
      S_XFER:    state_d = S_IDLE;
`ifdef XFER_SEQ_GAP_EN
      S_MAIN_LO: state_d = S_GAP;
      S_GAP:     state_d = S_MAIN_HI;
`else
      S_MAIN_LO: state_d = S_MAIN_HI;
`endif
      S_MAIN_HI: state_d = S_IDLE;
      S_ADDR: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default:   state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_XFER) || (state_d == S_MAIN_HI)
           || ((state_d == S_ADDR) && (cnt_d == '0));

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      assert_addr_d[i] = !((state_d == S_ADDR)    && (src_d == IDX_W'(i)));
      assert_xfer_d[i] = !((state_d == S_XFER)    && (src_d == IDX_W'(i)));
      load_xfer_d[i]   = !((state_d == S_XFER)    && (dst_d == IDX_W'(i)));
      assertlow_d[i]   = !((state_d == S_MAIN_LO) && (src_d == IDX_W'(i)));
      loadlow_d[i]     = !((state_d == S_MAIN_LO) && (dst_d == IDX_W'(i)));
      asserthigh_d[i]  = !((state_d == S_MAIN_HI) && (src_d == IDX_W'(i)));
      loadhigh_d[i]    = !((state_d == S_MAIN_HI) && (dst_d == IDX_W'(i)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      cnt_q         <= '0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      assert_addr_q <= '1;
      assert_xfer_q <= '1;
      load_xfer_q   <= '1;
      assertlow_q   <= '1;
      asserthigh_q  <= '1;
      loadlow_q     <= '1;
      loadhigh_q    <= '1;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      err_q         <= err_d;
      assert_addr_q <= assert_addr_d;
      assert_xfer_q <= assert_xfer_d;
      load_xfer_q   <= load_xfer_d;
      assertlow_q   <= assertlow_d;
      asserthigh_q  <= asserthigh_d;
      loadlow_q     <= loadlow_d;
      loadhigh_q    <= loadhigh_d;
    end
  end

  assign req_ready         = ready_q;
  assign done              = done_q;
  assign err               = err_q;
  assign assert_addr_n     = assert_addr_q;
  assign assert_xfer_n     = assert_xfer_q;
  assign load_xfer_n       = load_xfer_q;
  assign assertlow_main_n  = assertlow_q;
  assign asserthigh_main_n = asserthigh_q;
  assign loadlow_main_n    = loadlow_q;
  assign loadhigh_main_n   = loadhigh_q;

endmodule
